// File: rtl/vga_hsync.sv
// rtl/vga_hsync.sv - horizontal timing generator for 640x480 VGA
//
// Walks SYNC -> BACK -> DISP -> FRONT, with a 10-bit position counter
// inside each phase. All outputs are registered with the phase/position
// state, so they are glitch-free and in phase with each other.
//
// Optional feature macro: VGA_HSYNC_PIX_DIV_EN
//   defined   : internal divide-by-2 register drives pix_en (50 MHz clk,
//               25 MHz pixel rate)
//   undefined : pix_en tied high, clk is the pixel clock
//
// Parameters (each 1..1023):
//   H_SYNC, H_BACK, H_DISP, H_FRONT - phase widths in pixel periods
//
// Ports:
//   clk       - system clock
//   rst       - asynchronous active-low reset
//   H_sync    - horizontal sync, low during SYNC
//   line_clk  - ~H_sync; one rising edge per line, at the start of sync
//   h_display - high during DISP
//   col_count - pixel column during DISP, 0 elsewhere
//   pix_en    - pixel-advance qualifier

module vga_hsync #(
    parameter int H_SYNC  = 96,
    parameter int H_BACK  = 48,
    parameter int H_DISP  = 640,
    parameter int H_FRONT = 16
) (
    input  logic       clk,
    input  logic       rst,
    output logic       H_sync,
    output logic       line_clk,
    output logic       h_display,
    output logic [9:0] col_count,
    output logic       pix_en
);

    localparam logic [9:0] SYNC_LAST  = 10'(H_SYNC - 1);
    localparam logic [9:0] BACK_LAST  = 10'(H_BACK - 1);
    localparam logic [9:0] DISP_LAST  = 10'(H_DISP - 1);
    localparam logic [9:0] FRONT_LAST = 10'(H_FRONT - 1);

    typedef enum logic [1:0] {
        PH_SYNC  = 2'd0,
        PH_BACK  = 2'd1,
        PH_DISP  = 2'd2,
        PH_FRONT = 2'd3
    } phase_t;

    phase_t     phase;
    phase_t     phase_nxt;
    logic [9:0] pos;
    logic [9:0] pos_nxt;
    logic [9:0] phase_last;

`ifdef VGA_HSYNC_PIX_DIV_EN
    logic pix_div;

    // Starts at 0 so the first advance after reset lands on the second edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pix_div <= 1'b0;
        end else begin
            pix_div <= ~pix_div;
        end
    end

    assign pix_en = pix_div;
`else
    assign pix_en = 1'b1;
`endif

    always_comb begin
        phase_last = SYNC_LAST;
        unique case (phase)
            PH_SYNC:  phase_last = SYNC_LAST;
            PH_BACK:  phase_last = BACK_LAST;
            PH_DISP:  phase_last = DISP_LAST;
            PH_FRONT: phase_last = FRONT_LAST;
            default:  phase_last = SYNC_LAST;
        endcase
    end

    // Next-state logic; with pix_en low the next state equals the current
    // state, so the registered outputs below simply hold.
    always_comb begin
        phase_nxt = phase;
        pos_nxt   = pos;
        if (pix_en) begin
            if (pos == phase_last) begin
                pos_nxt = 10'd0;
                unique case (phase)
                    PH_SYNC:  phase_nxt = PH_BACK;
                    PH_BACK:  phase_nxt = PH_DISP;
                    PH_DISP:  phase_nxt = PH_FRONT;
                    PH_FRONT: phase_nxt = PH_SYNC;
                    default:  phase_nxt = PH_SYNC;
                endcase
            end else begin
                pos_nxt = pos + 10'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            phase <= PH_SYNC;
            pos   <= 10'd0;
        end else begin
            phase <= phase_nxt;
            pos   <= pos_nxt;
        end
    end

    // Outputs are decoded from the next state so they change on the same
    // edge as the state they describe, with no combinational decode after
    // the flops.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            H_sync    <= 1'b0;
            line_clk  <= 1'b1;
            h_display <= 1'b0;
            col_count <= 10'd0;
        end else begin
            H_sync    <= (phase_nxt != PH_SYNC);
            line_clk  <= (phase_nxt == PH_SYNC);
            h_display <= (phase_nxt == PH_DISP);
            col_count <= (phase_nxt == PH_DISP) ? pos_nxt : 10'd0;
        end
    end

endmodule

// File: tb/tb_vga_hsync.sv
// tb/tb_vga_hsync.sv - self-checking bench for vga_hsync (default parameters)

module tb_vga_hsync;

    localparam int SYNC_W     = 96;
    localparam int DISP_START = 144;
    localparam int DISP_W     = 640;
    localparam int FRONT_W    = 16;
    localparam int LINE       = 800;
`ifdef VGA_HSYNC_PIX_DIV_EN
    localparam int K = 2;
`else
    localparam int K = 1;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       H_sync;
    logic       line_clk;
    logic       h_display;
    logic [9:0] col_count;
    logic       pix_en;

    vga_hsync dut (
        .clk       (clk),
        .rst       (rst),
        .H_sync    (H_sync),
        .line_clk  (line_clk),
        .h_display (h_display),
        .col_count (col_count),
        .pix_en    (pix_en)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            if (n_fail <= 50)
                $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: a single pixel index within the line.
    int m_p   = 0;
    bit m_div = 1'b0;
    bit m_en;
`ifdef VGA_HSYNC_PIX_DIV_EN
    assign m_en = m_div;
`else
    assign m_en = 1'b1;
`endif

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_p   <= 0;
            m_div <= 1'b0;
        end else begin
            if (m_en) m_p <= (m_p + 1) % LINE;
            m_div <= !m_div;
        end
    end

    always @(negedge clk) begin
        int disp;
        disp = (m_p >= DISP_START && m_p < DISP_START + DISP_W) ? 1 : 0;
        check("H_sync",    int'(H_sync),    (m_p >= SYNC_W) ? 1 : 0);
        check("line_clk",  int'(line_clk),  (m_p < SYNC_W) ? 1 : 0);
        check("h_display", int'(h_display), disp);
        check("col_count", int'(col_count), disp ? m_p - DISP_START : 0);
        check("pix_en",    int'(pix_en),    int'(m_en));
    end

    task automatic wait_fall(output bit found);
        logic prev;
        found = 1'b0;
        @(negedge clk);
        prev = H_sync;
        for (int j = 0; j < 2 * LINE * K + 10; j++) begin
            @(negedge clk);
            if (prev && !H_sync) begin
                found = 1'b1;
                break;
            end
            prev = H_sync;
        end
        check("hsync_fall_found", int'(found), 1);
    endtask

    task automatic measure_line();
        bit   found;
        logic prev;
        int   low_w, rise, disp_w, max_col, col_err, period;
        wait_fall(found);
        if (!found) return;
        low_w = -1; rise = -1; disp_w = 0; max_col = 0; col_err = 0; period = -1;
        prev = H_sync;
        for (int i = 0; i < 2 * LINE * K + 10; i++) begin
            if (i > 0) begin
                @(negedge clk);
                if (prev && !H_sync) begin
                    period = i;
                    break;
                end
            end
            if (H_sync && low_w < 0) low_w = i;
            if (h_display) begin
                if (rise < 0) rise = i;
                disp_w++;
                if (int'(col_count) > max_col) max_col = int'(col_count);
                if (int'(col_count) != (i - rise) / K) col_err++;
            end
            prev = H_sync;
        end
        check("sync_low_width", low_w,  SYNC_W * K);
        check("disp_rise",      rise,   DISP_START * K);
        check("disp_width",     disp_w, DISP_W * K);
        check("max_col",        max_col, DISP_W - 1);
        check("col_sequence",   col_err, 0);
        check("line_period",    period, LINE * K);
        check("front_porch",    period - rise - disp_w, FRONT_W * K);
    endtask

    initial begin
        bit   found;
        int   rises, coinc, n;
        logic prev_l, prev_h;

        // Reset for three clocks, then release away from the edge.
        #1 rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_H_sync",    int'(H_sync),    0);
        check("rst_line_clk",  int'(line_clk),  1);
        check("rst_h_display", int'(h_display), 0);
        check("rst_col_count", int'(col_count), 0);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("rel_H_sync",    int'(H_sync),    0);
        check("rel_line_clk",  int'(line_clk),  1);
        check("rel_h_display", int'(h_display), 0);
        check("rel_col_count", int'(col_count), 0);

        measure_line();

        // Line clock: one rise per line, coincident with the sync fall.
        wait_fall(found);
        rises = 0; coinc = 0;
        prev_l = line_clk; prev_h = H_sync;
        repeat (20 * LINE * K) begin
            @(negedge clk);
            if (!prev_l && line_clk) begin
                rises++;
                if (prev_h && !H_sync) coinc++;
            end
            prev_l = line_clk; prev_h = H_sync;
        end
        check("line_clk_rises",      rises, 20);
        check("line_clk_coincident", coinc, 20);

        // Asynchronous reset in the middle of the display window.
        found = 1'b0;
        for (int j = 0; j < 2 * LINE * K; j++) begin
            @(negedge clk);
            if (h_display && col_count == 10'd300) begin
                found = 1'b1;
                break;
            end
        end
        check("col300_found", int'(found), 1);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_H_sync",    int'(H_sync),    0);
        check("mid_line_clk",  int'(line_clk),  1);
        check("mid_h_display", int'(h_display), 0);
        check("mid_col_count", int'(col_count), 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        n = 0;
        for (int j = 1; j <= LINE * K; j++) begin
            @(posedge clk);
            #1;
            if (h_display) begin
                n = j;
                break;
            end
        end
        check("disp_after_reset", n, DISP_START * K);

        // Random run lengths with random reset pulses, checked by the model.
        for (int it = 0; it < 12; it++) begin
            repeat ($urandom_range(20, 2000)) @(posedge clk);
            #($urandom_range(1, 3)) rst = 1'b0;
            if ($urandom_range(0, 1) == 0) begin
                #1 rst = 1'b1;
            end else begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #($urandom_range(1, 3)) rst = 1'b1;
            end
        end

        measure_line();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
